// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared types and constants for the shift arbiter
package shift_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10,
    SHIFT_ILL = 2'b11
  } shift_op_e;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/shift_core.sv
// rtl/shift_core.sv - combinational five-stage logarithmic shifter
module shift_core
  import shift_pkg::*;
(
  input  logic [XLEN-1:0]    data,
  input  logic [SHAMT_W-1:0] shamt,
  input  shift_op_e          op,
  output logic [XLEN-1:0]    result,
  output logic               illegal
);

  logic [XLEN-1:0] cur;
  logic            fill;
  logic            left;

  // Stages of 1, 2, 4, 8, 16; right shifts OR in a fill mask so SRA replicates the sign bit.
  always_comb begin
    left    = (op == SHIFT_SLL);
    fill    = (op == SHIFT_SRA) ? data[XLEN-1] : 1'b0;
    illegal = (op == SHIFT_ILL);
    cur     = data;
    for (int s = 0; s < SHAMT_W; s++) begin
      if (shamt[s]) begin
        if (left) begin
          cur = cur << (1 << s);
        end else begin
          cur = (cur >> (1 << s)) | ({XLEN{fill}} & ~({XLEN{1'b1}} >> (1 << s)));
        end
      end
    end
    result = illegal ? data : cur;
  end

endmodule

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin arbiter sharing one shifter among requesters
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int  NUM_REQ = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  output logic [NUM_REQ-1:0]         o_req_ready,
  input  logic [NUM_REQ*XLEN-1:0]    i_req_data,
  input  logic [NUM_REQ*SHAMT_W-1:0] i_req_shamt,
  input  logic [NUM_REQ*2-1:0]       i_req_op,
  output logic                       o_rsp_valid,
  input  logic                       i_rsp_ready,
  output logic [XLEN-1:0]            o_rsp_result,
  output logic [ID_W-1:0]            o_rsp_id,
  output logic                       o_rsp_illegal
);

  rsp_state_e          state_q, state_d;
  logic [ID_W-1:0]     rr_ptr, ptr_next, grant_idx;
  logic                grant_valid, can_accept, accept;
  logic [XLEN-1:0]     sel_data, core_result;
  logic [SHAMT_W-1:0]  sel_shamt;
  shift_op_e           sel_op;
  logic                core_illegal;

  // Scan valids starting at rr_ptr, wrapping, and take the first one found.
  always_comb begin : grant_scan
    int j;
    grant_valid = 1'b0;
    grant_idx   = '0;
    j           = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!grant_valid && i_req_valid[ID_W'(j)]) begin
        grant_valid = 1'b1;
        grant_idx   = ID_W'(j);
      end
    end
  end

  // Payload mux onto the single shared shifter.
  always_comb begin
    sel_data  = '0;
    sel_shamt = '0;
    sel_op    = SHIFT_SLL;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == ID_W'(k)) begin
        sel_data  = i_req_data[k*XLEN +: XLEN];
        sel_shamt = i_req_shamt[k*SHAMT_W +: SHAMT_W];
        sel_op    = shift_op_e'(i_req_op[k*2 +: 2]);
      end
    end
  end

  shift_core u_core (
    .data    (sel_data),
    .shamt   (sel_shamt),
    .op      (sel_op),
    .result  (core_result),
    .illegal (core_illegal)
  );

  assign o_rsp_valid = (state_q == RSP_FULL);
  assign can_accept  = !o_rsp_valid || i_rsp_ready;
  assign accept      = |o_req_ready;
  assign ptr_next    = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;

  // One-hot ready to the granted requester; suppressed during reset so nothing is accepted.
  always_comb begin
    o_req_ready = '0;
    if (!i_reset && can_accept && grant_valid) o_req_ready[grant_idx] = 1'b1;
  end

  // Response occupancy: fill on accept, empty on drain without refill.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RSP_EMPTY: if (accept) state_d = RSP_FULL;
      RSP_FULL:  if (!accept && i_rsp_ready) state_d = RSP_EMPTY;
      default:   state_d = RSP_EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= RSP_EMPTY;
    else         state_q <= state_d;
  end

  // Response payload and round-robin pointer advance only on accept; otherwise they hold.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_rsp_result  <= '0;
      o_rsp_id      <= '0;
      o_rsp_illegal <= 1'b0;
      rr_ptr        <= '0;
    end else if (accept) begin
      o_rsp_result  <= core_result;
      o_rsp_id      <= grant_idx;
      o_rsp_illegal <= core_illegal;
      rr_ptr        <= ptr_next;
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - directed self-checking bench for shift_arbiter
module tb_shift_arbiter;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // NUM_REQ = 2 instance
  logic        rst2;
  logic [1:0]  v2, rdy2;
  logic [63:0] d2;
  logic [9:0]  sh2;
  logic [3:0]  op2;
  logic        rv2, rr2, ill2;
  logic [31:0] res2;
  logic        id2;

  // NUM_REQ = 4 instance
  logic         rst4;
  logic [3:0]   v4, rdy4;
  logic [127:0] d4;
  logic [19:0]  sh4;
  logic [7:0]   op4;
  logic         rv4, rr4, ill4;
  logic [31:0]  res4;
  logic [1:0]   id4;

  shift_arbiter #(.NUM_REQ(2)) dut2 (
    .i_clk(clk), .i_reset(rst2), .i_req_valid(v2), .o_req_ready(rdy2),
    .i_req_data(d2), .i_req_shamt(sh2), .i_req_op(op2),
    .o_rsp_valid(rv2), .i_rsp_ready(rr2), .o_rsp_result(res2),
    .o_rsp_id(id2), .o_rsp_illegal(ill2)
  );

  shift_arbiter #(.NUM_REQ(4)) dut4 (
    .i_clk(clk), .i_reset(rst4), .i_req_valid(v4), .o_req_ready(rdy4),
    .i_req_data(d4), .i_req_shamt(sh4), .i_req_op(op4),
    .o_rsp_valid(rv4), .i_rsp_ready(rr4), .o_rsp_result(res4),
    .o_rsp_id(id4), .o_rsp_illegal(ill4)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [1:0]  op;
    logic [31:0] exp;
    logic        exp_ill;
  } vec_t;

  vec_t vecs [14];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   id_count [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req2(input int k, input logic [31:0] d, input logic [4:0] s, input logic [1:0] o);
    d2[k*32 +: 32] = d;
    sh2[k*5 +: 5]  = s;
    op2[k*2 +: 2]  = o;
  endtask

  task automatic reset2();
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000, 1'b0};
    vecs[1]  = '{32'h1234_5678, 5'd0,  2'b00, 32'h1234_5678, 1'b0};
    vecs[2]  = '{32'hDEAD_BEEF, 5'd7,  2'b11, 32'hDEAD_BEEF, 1'b1};
    vecs[3]  = '{32'h8000_0001, 5'd31, 2'b10, 32'hFFFF_FFFF, 1'b0};
    vecs[4]  = '{32'h7FFF_FFFF, 5'd31, 2'b10, 32'h0000_0000, 1'b0};
    vecs[5]  = '{32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, 1'b0};
    vecs[6]  = '{32'hFFFF_FFFF, 5'd1,  2'b01, 32'h7FFF_FFFF, 1'b0};
    vecs[7]  = '{32'h1234_5678, 5'd8,  2'b00, 32'h3456_7800, 1'b0};
    vecs[8]  = '{32'h1234_5678, 5'd12, 2'b01, 32'h0001_2345, 1'b0};
    vecs[9]  = '{32'hF000_0000, 5'd3,  2'b01, 32'h1E00_0000, 1'b0};
    vecs[10] = '{32'h8000_F000, 5'd16, 2'b10, 32'hFFFF_8000, 1'b0};
    vecs[11] = '{32'h0000_0003, 5'd5,  2'b00, 32'h0000_0060, 1'b0};
    vecs[12] = '{32'hDEAD_BEEF, 5'd0,  2'b10, 32'hDEAD_BEEF, 1'b0};
    vecs[13] = '{32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001, 1'b0};

    rst2 = 1'b1; v2 = '0; d2 = '0; sh2 = '0; op2 = '0; rr2 = 1'b1;
    rst4 = 1'b1; v4 = '0; d4 = '0; sh4 = '0; op4 = '0; rr4 = 1'b1;
    tick();

    // Reset state: ready blocked during reset even with a valid request.
    v2 = 2'b01;
    set_req2(0, 32'h1, 5'd1, 2'b00);
    #1;
    check("ready_in_reset", 32'(rdy2), 32'h0);
    tick();
    check("reset_valid", 32'(rv2), 32'h0);
    check("reset_result", res2, 32'h0);
    check("reset_id", 32'(id2), 32'h0);
    check("reset_illegal", 32'(ill2), 32'h0);
    rst2 = 1'b0;
    rst4 = 1'b0;

    // Table: single requester 0, one result per cycle.
    for (int i = 0; i < 14; i++) begin
      v2 = 2'b01;
      set_req2(0, vecs[i].data, vecs[i].shamt, vecs[i].op);
      #1;
      check($sformatf("vec%0d_ready", i), 32'(rdy2), 32'h1);
      tick();
      check($sformatf("vec%0d_valid", i), 32'(rv2), 32'h1);
      check($sformatf("vec%0d_result", i), res2, vecs[i].exp);
      check($sformatf("vec%0d_id", i), 32'(id2), 32'h0);
      check($sformatf("vec%0d_illegal", i), 32'(ill2), 32'(vecs[i].exp_ill));
    end

    // Drain without refill: valid drops, payload holds.
    v2 = 2'b00;
    tick();
    check("drain_valid", 32'(rv2), 32'h0);
    check("drain_hold", res2, 32'h0000_0001);

    // Round-robin alternation from a fresh pointer.
    reset2();
    set_req2(0, 32'h0000_0001, 5'd31, 2'b00);
    set_req2(1, 32'hFFFF_FFFF, 5'd1, 2'b01);
    v2 = 2'b11;
    rr2 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("rr%0d_ready", k), 32'(rdy2), (k % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      check($sformatf("rr%0d_valid", k), 32'(rv2), 32'h1);
      check($sformatf("rr%0d_id", k), 32'(id2), 32'(k % 2));
      check($sformatf("rr%0d_result", k), res2, (k % 2 == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF);
    end

    // Backpressure: response from id 1 must sit still for three cycles.
    rr2 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp%0d_ready", k), 32'(rdy2), 32'h0);
      tick();
      check($sformatf("bp%0d_valid", k), 32'(rv2), 32'h1);
      check($sformatf("bp%0d_id", k), 32'(id2), 32'h1);
      check($sformatf("bp%0d_result", k), res2, 32'h7FFF_FFFF);
    end
    rr2 = 1'b1;
    #1;
    check("bp_release_ready", 32'(rdy2), 32'h1);
    tick();
    check("bp_refill_valid", 32'(rv2), 32'h1);
    check("bp_refill_id", 32'(id2), 32'h0);
    check("bp_refill_result", res2, 32'h8000_0000);

    // Mid-stream reset while FULL and stalled.
    rr2 = 1'b0;
    rst2 = 1'b1;
    #1;
    check("midrst_ready", 32'(rdy2), 32'h0);
    tick();
    rst2 = 1'b0;
    check("midrst_valid", 32'(rv2), 32'h0);
    check("midrst_result", res2, 32'h0);
    rr2 = 1'b1;
    #1;
    check("midrst_grant", 32'(rdy2), 32'h1);
    tick();
    check("midrst_id", 32'(id2), 32'h0);
    check("midrst_res", res2, 32'h8000_0000);
    v2 = 2'b00;

    // Fairness with four requesters.
    for (int k = 0; k < 4; k++) begin
      d4[k*32 +: 32] = 32'h1 << k;
      sh4[k*5 +: 5]  = 5'(k);
      op4[k*2 +: 2]  = 2'b00;
      id_count[k]    = 0;
    end
    v4 = 4'hF;
    rr4 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      check($sformatf("fair%0d_ready", i), 32'(rdy4), 32'h1 << (i % 4));
      tick();
      check($sformatf("fair%0d_id", i), 32'(id4), 32'(i % 4));
      check($sformatf("fair%0d_result", i), res4, 32'h1 << (2 * (i % 4)));
      if (rv4) id_count[id4]++;
    end
    for (int k = 0; k < 4; k++) check($sformatf("fair_count%0d", k), 32'(id_count[k]), 32'd3);
    v4 = 4'h0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
